// File: rtl/keypad_scan_4x4_if.sv
// Keypad-side and key-bus signals of the 4x4 scanner.
// master = scanner (drives rows and key outputs); slave = keypad/consumer side.
interface keypad_scan_4x4_if;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] onehot;
  logic [3:0]  key_code;
  logic        key_valid;

  modport master (
    input  col_in,
    output row_out,
    output onehot,
    output key_code,
    output key_valid
  );

  modport slave (
    output col_in,
    input  row_out,
    input  onehot,
    input  key_code,
    input  key_valid
  );
endinterface

// File: rtl/keypad_scan_4x4.sv
// 4x4 keypad row scanner with whole-frame debounce; outputs a onehot key, its code and a new-key pulse.
// A clean press/release shows up at the end of the DEBOUNCE_FRAMES-th frame containing it; no backpressure.
module keypad_scan_4x4 #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  keypad_scan_4x4_if.master kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_row_idx;
  logic [3:0]       r_row_out;
  logic [11:0]      r_frame;
  logic [15:0]      r_prev_frame;
  logic [CNT_W-1:0] r_stable_cnt;
  logic [15:0]      r_onehot;
  logic [3:0]       r_key_code;
  logic             r_key_valid;

  logic             w_sample;
  logic             w_frame_end;
  logic [1:0]       w_row_nxt;
  logic [3:0]       w_raw;
  logic [15:0]      w_frm;
  logic [CNT_W-1:0] w_stable_nxt;
  logic             w_accept;
  logic [4:0]       w_pop;
  logic [3:0]       w_idx;
  logic [15:0]      w_new_oh;

  always_comb begin
    w_sample    = (r_div_cnt == DIV_LAST);
    w_frame_end = w_sample && (r_row_idx == 2'd3);
    w_row_nxt   = r_row_idx + 2'd1;
    w_raw       = ~kp.col_in;
    // Row 3 is never buffered: it is taken straight from the sample that closes the frame.
    w_frm       = {w_raw, r_frame};

    if (w_frm != r_prev_frame)
      w_stable_nxt = CNT_W'(1);
    else if (r_stable_cnt == CNT_MAX)
      w_stable_nxt = CNT_MAX;
    else
      w_stable_nxt = r_stable_cnt + CNT_W'(1);

    w_accept = w_frame_end && (w_stable_nxt == CNT_MAX);

    w_pop = 5'd0;
    w_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      w_pop = w_pop + 5'(w_frm[i]);
      if (w_frm[i])
        w_idx = 4'(i);
    end
    w_new_oh = (w_pop == 5'd1) ? w_frm : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_row_idx    <= 2'd0;
      r_row_out    <= 4'b1110;
      r_frame      <= 12'h000;
      r_prev_frame <= 16'h0000;
      r_stable_cnt <= '0;
      r_onehot     <= 16'h0000;
      r_key_code   <= 4'h0;
      r_key_valid  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;

      if (w_sample) begin
        r_div_cnt <= '0;
        r_row_idx <= w_row_nxt;
        r_row_out <= ~(4'b0001 << w_row_nxt);
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end

      if (w_sample) begin
        case (r_row_idx)
          2'd0:    r_frame[3:0]  <= w_raw;
          2'd1:    r_frame[7:4]  <= w_raw;
          2'd2:    r_frame[11:8] <= w_raw;
          default: ;
        endcase
      end

      if (w_frame_end) begin
        r_prev_frame <= w_frm;
        r_stable_cnt <= w_stable_nxt;
      end

      // Ghosted or empty snapshots clear the bus but keep the last code.
      if (w_accept && (w_new_oh != r_onehot)) begin
        r_onehot <= w_new_oh;
        if (w_new_oh != 16'h0000) begin
          r_key_valid <= 1'b1;
          r_key_code  <= w_idx;
        end
      end
    end
  end

  assign kp.row_out   = r_row_out;
  assign kp.onehot    = r_onehot;
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: keypad matrix model, per-cycle reference model, vector table and corner sequences.
module tb_keypad_scan_4x4;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int HOLD     = 80;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] keys;
  logic [3:0]  tb_cols;

  keypad_scan_4x4_if kp ();

  keypad_scan_4x4 #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kp.master)
  );

  always #5 clk = ~clk;

  // Ideal switch matrix: a closed key pulls its column low only while its row is driven low.
  always_comb begin
    tb_cols = 4'h0;
    for (int r = 0; r < 4; r++)
      if (!kp.row_out[r])
        tb_cols = tb_cols | keys[r*4 +: 4];
  end
  assign kp.col_in = ~tb_cols;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time since reset, last DEB whole frames, accepted key.
  int          m_t;
  logic [15:0] m_snap;
  logic [15:0] m_hist[$];
  logic [15:0] m_oh;
  logic [3:0]  m_code;
  logic        m_valid;
  logic [3:0]  m_row_out;

  task automatic model_reset();
    m_t       = 0;
    m_snap    = 16'h0;
    m_hist.delete();
    m_oh      = 16'h0;
    m_code    = 4'h0;
    m_valid   = 1'b0;
    m_row_out = 4'b1110;
  endtask

  task automatic model_step();
    int row;
    logic all_eq;
    logic [15:0] nv;
    row = (m_t / SCAN_DIV) % 4;
    m_valid = 1'b0;
    if ((m_t % SCAN_DIV) == SCAN_DIV - 1) begin
      m_snap[row*4 +: 4] = keys[row*4 +: 4];
      if (row == 3) begin
        m_hist.push_back(m_snap);
        if (m_hist.size() > DEB)
          void'(m_hist.pop_front());
        if (m_hist.size() == DEB) begin
          all_eq = 1'b1;
          foreach (m_hist[i])
            if (m_hist[i] != m_snap) all_eq = 1'b0;
          if (all_eq) begin
            nv = ($countones(m_snap) == 1) ? m_snap : 16'h0;
            if (nv != m_oh) begin
              m_oh = nv;
              if (nv != 16'h0) begin
                m_valid = 1'b1;
                for (int b = 0; b < 16; b++)
                  if (nv[b]) m_code = 4'(b);
              end
            end
          end
        end
      end
    end
    m_t++;
    m_row_out = ~(4'b0001 << ((m_t / SCAN_DIV) % 4));
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      chk("row_out",   {12'h0, kp.row_out},  {12'h0, m_row_out});
      chk("onehot",    kp.onehot,            m_oh);
      chk("key_code",  {12'h0, kp.key_code}, {12'h0, m_code});
      chk("key_valid", {15'h0, kp.key_valid}, {15'h0, m_valid});
      if (kp.key_valid === 1'b1) pulses++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  typedef struct {
    logic [15:0] keys;
    logic [15:0] oh;
    logic [3:0]  code;
    int          npulse;
  } vec_t;

  vec_t tbl[10];
  int   base;

  initial begin
    tbl[0] = '{16'h0000, 16'h0000, 4'd0,  0};
    tbl[1] = '{16'h0040, 16'h0040, 4'd6,  1};
    tbl[2] = '{16'h0000, 16'h0000, 4'd6,  0};
    tbl[3] = '{16'h0801, 16'h0000, 4'd6,  0};
    tbl[4] = '{16'h0001, 16'h0001, 4'd0,  1};
    tbl[5] = '{16'h8000, 16'h8000, 4'd15, 1};
    tbl[6] = '{16'h0008, 16'h0008, 4'd3,  1};
    tbl[7] = '{16'h0000, 16'h0000, 4'd3,  0};
    tbl[8] = '{16'h0400, 16'h0400, 4'd10, 1};
    tbl[9] = '{16'h0400, 16'h0400, 4'd10, 0};

    rst_n = 1'b0;
    keys  = 16'h0;
    wait_cyc(3);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      keys = tbl[i].keys;
      base = pulses;
      wait_cyc(HOLD);
      chk($sformatf("tbl%0d_onehot", i), kp.onehot, tbl[i].oh);
      chk($sformatf("tbl%0d_code", i), {12'h0, kp.key_code}, {12'h0, tbl[i].code});
      chk($sformatf("tbl%0d_pulses", i), 16'(pulses - base), 16'(tbl[i].npulse));
    end

    // Bounce on row1/col2, then settle.
    keys = 16'h0;
    wait_cyc(HOLD);
    base = pulses;
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      wait_cyc(5);
    end
    chk("bounce_hold_zero", kp.onehot, 16'h0000);
    keys = 16'h0040;
    wait_cyc(HOLD);
    chk("bounce_onehot", kp.onehot, 16'h0040);
    chk("bounce_pulses", 16'(pulses - base), 16'd1);

    // Reset mid-frame with a key accepted and still held.
    wait_cyc(7);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_onehot", kp.onehot, 16'h0000);
    chk("rst_async_row",    {12'h0, kp.row_out}, 16'h000e);
    chk("rst_async_valid",  {15'h0, kp.key_valid}, 16'h0);
    wait_cyc(2);
    rst_n = 1'b1;
    base = pulses;
    wait_cyc(HOLD);
    chk("rst_reaccept_onehot", kp.onehot, 16'h0040);
    chk("rst_reaccept_pulses", 16'(pulses - base), 16'd1);

    // Random key patterns with random hold times, checked by the model every cycle.
    for (int it = 0; it < 30; it++) begin
      int sel;
      int k0;
      int k1;
      logic [15:0] one;
      one = 16'h0001;
      sel = $urandom_range(0, 3);
      k0  = $urandom_range(0, 15);
      k1  = $urandom_range(0, 15);
      case (sel)
        0:       keys = 16'h0;
        1, 2:    keys = one << k0;
        default: keys = (one << k0) | (one << k1);
      endcase
      wait_cyc($urandom_range(3, 100));
    end
    keys = 16'h0;
    wait_cyc(HOLD);
    chk("final_release", kp.onehot, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
